// File: rtl/rr_mux4.sv
// 4:1 round-robin packet-aware stream mux tagging each beat with its source index.
// Latency 1 cycle accept->out_valid; output register drains and reloads in one cycle, in_ready=0 while it is held.
module rr_mux4 #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            in_valid,
    input  logic [4*DATA_W-1:0]   in_data,
    input  logic [3:0]            in_last,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic [1:0]            out_sel,
    input  logic                  out_ready
);

    typedef enum logic {ARB, LOCKED} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              last;
        logic [1:0]        sel;
    } beat_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] lock_ch, lock_nxt;
    logic [1:0] win;
    logic [1:0] idx;
    logic       win_vld;
    logic       can_load;
    logic       load;
    logic       beat_vld;
    beat_t      beat_q;

    // Scan from the highest offset down so the channel closest to ptr wins.
    always_comb begin
        win     = ptr;
        win_vld = 1'b0;
        idx     = ptr;
        if (state == LOCKED) begin
            win     = lock_ch;
            win_vld = in_valid[lock_ch];
        end else begin
            for (int k = 3; k >= 0; k--) begin
                idx = ptr + 2'(k);
                if (in_valid[idx]) begin
                    win     = idx;
                    win_vld = 1'b1;
                end
            end
        end
    end

    // No grant while reset is held: a beat accepted on that edge would be lost.
    assign can_load = !beat_vld || out_ready;
    assign load     = win_vld && can_load && !rst;
    assign in_ready = load ? (4'b0001 << win) : 4'b0000;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock_ch;
        if (load) begin
            if (in_last[win]) begin
                state_nxt = ARB;
                ptr_nxt   = win + 2'd1;
            end else begin
                state_nxt = LOCKED;
                lock_nxt  = win;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= 2'b00;
            lock_ch  <= 2'b00;
            beat_vld <= 1'b0;
            beat_q   <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            lock_ch <= lock_nxt;
            if (load) begin
                beat_vld    <= 1'b1;
                beat_q.dat  <= in_data[win*DATA_W +: DATA_W];
                beat_q.last <= in_last[win];
                beat_q.sel  <= win;
            end else if (out_ready) begin
                beat_vld <= 1'b0;
            end
        end
    end

    assign out_valid = beat_vld;
    assign out_data  = beat_q.dat;
    assign out_last  = beat_q.last;
    assign out_sel   = beat_q.sel;

endmodule

// File: tb/tb_rr_mux4.sv
// Directed bench for rr_mux4: round-robin order, packet lock, backpressure, wrap, async reset.
module tb_rr_mux4;

    localparam int DATA_W = 8;

    logic                clk;
    logic                rst;
    logic [3:0]          in_valid;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_last;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;
    logic [1:0]          out_sel;
    logic                out_ready;

    int checks   = 0;
    int failures = 0;

    rr_mux4 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic setin(input logic [3:0] v, input logic [3:0] l, input logic r);
        in_valid  = v;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs, check the combinational grant, then clock it in.
    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic r,
                        input logic [3:0] exp_rdy, input string tag);
        setin(v, l, r);
        #1;
        chk(tag, 32'(in_ready), 32'(exp_rdy));
        tick();
    endtask

    task automatic chk_out(input string tag, input logic [1:0] sel, input logic [7:0] dat);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_sel"}, 32'(out_sel), 32'(sel));
        chk({tag, "_dat"}, 32'(out_data), 32'(dat));
    endtask

    initial begin
        rst = 1'b1;
        setin(4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) in_data[i*DATA_W +: DATA_W] = 8'h10 + 8'(i);
        #12;
        chk("rst_vld",  32'(out_valid), 32'd0);
        chk("rst_dat",  32'(out_data),  32'd0);
        chk("rst_last", 32'(out_last),  32'd0);
        chk("rst_sel",  32'(out_sel),   32'd0);
        rst = 1'b0;
        tick();

        // Async reset mid-cycle clears a held beat immediately.
        step(4'b0100, 4'b0100, 1'b1, 4'b0100, "t1_rdy");
        chk_out("t1_load", 2'd2, 8'h12);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_vld", 32'(out_valid), 32'd0);
        chk("t1_async_sel", 32'(out_sel),   32'd0);
        chk("t1_async_rdy", 32'(in_ready),  32'd0);
        setin(4'b0000, 4'b0000, 1'b1);
        #2 rst = 1'b0;
        tick();

        // Round robin over all four single-beat packets, wrapping back to 0.
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 1'b1, 4'b0001 << (k % 4), "t2_rdy");
            chk_out("t2_out", 2'(k % 4), 8'h10 + 8'(k % 4));
        end

        // Ch2 three-beat packet holds the output; ch0/ch1 wait, bubble while ch2 idles.
        step(4'b0100, 4'b1011, 1'b1, 4'b0100, "t3_b1_rdy");
        chk_out("t3_b1", 2'd2, 8'h12);
        chk("t3_b1_last", 32'(out_last), 32'd0);
        step(4'b0011, 4'b1011, 1'b1, 4'b0000, "t3_bubble_rdy");
        chk("t3_bubble_vld", 32'(out_valid), 32'd0);
        step(4'b0111, 4'b1011, 1'b1, 4'b0100, "t3_b2_rdy");
        chk_out("t3_b2", 2'd2, 8'h12);
        step(4'b0111, 4'b1111, 1'b1, 4'b0100, "t3_b3_rdy");
        chk_out("t3_b3", 2'd2, 8'h12);
        chk("t3_b3_last", 32'(out_last), 32'd1);
        step(4'b0011, 4'b1111, 1'b1, 4'b0001, "t3_next_rdy");
        chk_out("t3_next", 2'd0, 8'h10);

        // Backpressure: A5 from ch1 held for 5 cycles, then drain+load together.
        in_data[1*DATA_W +: DATA_W] = 8'hA5;
        step(4'b0010, 4'b1111, 1'b1, 4'b0010, "t4_load_rdy");
        chk_out("t4_load", 2'd1, 8'hA5);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b1111, 1'b0, 4'b0000, "t4_hold_rdy");
            chk_out("t4_hold", 2'd1, 8'hA5);
            chk("t4_hold_last", 32'(out_last), 32'd1);
        end
        step(4'b1111, 4'b1111, 1'b1, 4'b0100, "t4_release_rdy");
        chk_out("t4_release", 2'd2, 8'h12);

        // Ch3 grant wraps ptr to 0, so ch0 beats ch3 next cycle.
        step(4'b1000, 4'b1111, 1'b1, 4'b1000, "t5_ch3_rdy");
        chk_out("t5_ch3", 2'd3, 8'h13);
        step(4'b1001, 4'b1111, 1'b1, 4'b0001, "t5_wrap_rdy");
        chk_out("t5_wrap", 2'd0, 8'h10);

        // Reset during a locked ch1 packet releases the lock and restarts at ch0.
        step(4'b0010, 4'b0000, 1'b1, 4'b0010, "t6_lock_rdy");
        chk_out("t6_lock", 2'd1, 8'hA5);
        setin(4'b1111, 4'b0000, 1'b1);
        #1;
        chk("t6_locked_rdy", 32'(in_ready), 32'b0010);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_vld", 32'(out_valid), 32'd0);
        chk("t6_async_rdy", 32'(in_ready),  32'd0);
        setin(4'b0000, 4'b0000, 1'b1);
        #2 rst = 1'b0;
        tick();
        step(4'b1111, 4'b1111, 1'b1, 4'b0001, "t6_after_rdy");
        chk_out("t6_after", 2'd0, 8'h10);
        step(4'b1111, 4'b1111, 1'b1, 4'b0010, "t6_next_rdy");
        chk_out("t6_next", 2'd1, 8'hA5);

        // Nothing valid: register drains, no grant.
        step(4'b0000, 4'b1111, 1'b1, 4'b0000, "drain_rdy");
        chk("drain_vld", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
